// File: rtl/uart_tx_result.sv
// -----------------------------------------------------------------------------
// uart_tx_result
//
// Sends one 8-bit result byte as an 8N1 UART frame (start bit, eight data bits
// LSB first, stop bit). The requester raises txflag and holds it until the
// one-cycle txzero acknowledge arrives. An internal "armed" flag means a held
// request can only ever produce one frame.
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the data
//                       bits) is inserted between the last data bit and the
//                       stop bit. When undefined, the parity state is absent.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous active-high reset
//   txdata - byte to send, captured when a frame starts
//   txflag - transmit request, level-held until txzero
//   tx     - serial line, idle high, driven from a register
//   txzero - one-cycle frame-complete acknowledge
//   busy   - high from the start bit until the acknowledge cycle
// -----------------------------------------------------------------------------
module uart_tx_result #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txdata,
    input  logic       txflag,
    output logic       tx,
    output logic       txzero,
    output logic       busy
);

    // Baud counter runs 0..CLKS_PER_BIT-1 inside every bit.
    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_armed;
    logic        w_armed_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_txzero;
    logic        w_txzero_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        w_bit_end;
    logic [7:0]  w_cnt_inc_unused;

    assign w_bit_end = (r_cnt == LastCnt);
    assign w_cnt_inc_unused = 8'd0;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = 16'd0;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_armed_nxt  = r_armed;
        w_tx_nxt     = r_tx;
        w_txzero_nxt = 1'b0;
        w_busy_nxt   = r_busy;

        // A low request in any cycle re-arms; launching needs txflag high, so
        // this never collides with the clear below.
        if (!txflag) begin
            w_armed_nxt = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (txflag && r_armed) begin
                    w_shift_nxt = txdata;
                    w_armed_nxt = 1'b0;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = StStart;
                end
            end

            StStart: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = StData;
                end
            end

            StData: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_bit_end) begin
                    w_cnt_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_idx_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = ^r_shift;
                        w_state_nxt = StParity;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = StStop;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                        w_tx_nxt  = r_shift[r_idx + 3'd1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = StStop;
                end
            end
`endif

            StStop: begin
                w_cnt_nxt = r_cnt + 16'd1;
                w_tx_nxt  = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt    = 16'd0;
                    w_txzero_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = StDone;
                end
            end

            StDone: begin
                // Acknowledge cycle; a launch is only possible from IDLE, so
                // the earliest next frame is one cycle later.
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = StIdle;
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = 3'd0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= 16'd0;
            r_idx    <= 3'd0;
            r_shift  <= 8'd0;
            r_armed  <= 1'b0;
            r_tx     <= 1'b1;
            r_txzero <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_armed  <= w_armed_nxt;
            r_tx     <= w_tx_nxt;
            r_txzero <= w_txzero_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign tx     = r_tx;
    assign txzero = r_txzero;
    assign busy   = r_busy;

endmodule
